// File: rtl/bp_trace_funnel_pkg.sv
// bp_trace_funnel_pkg: Nexus trace packet type, message codes and funnel FSM states.
package bp_trace_funnel_pkg;
  typedef struct packed {
    logic [5:0]  mcode;
    logic [31:0] addr;
  } nexus_trace_pkt_s;
  localparam logic [5:0] NEXUS_MCODE_DIRECT_BR = 6'h03;
  localparam logic [5:0] NEXUS_MCODE_INDIRECT_BR = 6'h04;
  localparam logic [5:0] NEXUS_MCODE_SYNC = 6'h09;
  typedef enum logic {S_SYNC, S_DATA} funnel_state_e;
endpackage

// File: rtl/bp_rr_arbiter.sv
// bp_rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module bp_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      grant_idx_o
);
  logic found;
  int   j;
  always_comb begin
    grant_o = '0;
    grant_idx_o = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found = 1'b1;
        grant_o[j] = 1'b1;
        grant_idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/bp_trace_funnel.sv
// bp_trace_funnel: round-robin funnel of trace encoders onto one registered Nexus port,
// with a Program Trace Sync packet forced after every SYNC_PERIOD data packets.
module bp_trace_funnel
  import bp_trace_funnel_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int SYNC_PERIOD = 16,
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  nexus_trace_pkt_s src_pkt_i [NUM_SRC],
  input  logic [NUM_SRC-1:0] src_valid_i,
  output logic [NUM_SRC-1:0] src_ready_o,
  output nexus_trace_pkt_s trace_pkt_o,
  output logic [SW-1:0]    trace_src_o,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [7:0]       sync_cnt_o
);
  funnel_state_e    state_q;
  logic [SW-1:0]    rr_q, src_q, gidx;
  logic [7:0]       data_cnt_q, data_cnt_d, sync_cnt_q;
  logic [31:0]      last_addr_q [NUM_SRC];
  nexus_trace_pkt_s pkt_q;
  logic             valid_q, ld_en;
  logic [NUM_SRC-1:0] grant;
  bp_rr_arbiter #(.NUM_REQ(NUM_SRC)) u_arb (
    .req_i(src_valid_i),
    .ptr_i(rr_q),
    .grant_o(grant),
    .grant_idx_o(gidx)
  );
  assign ld_en = ~valid_q | trace_ready_i;
  assign data_cnt_d = data_cnt_q + 8'd1;
  // Gated by reset so nothing is consumed while the funnel is being cleared.
  assign src_ready_o = (state_q == S_DATA && ld_en && !reset_i) ? grant : '0;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_SYNC;
      rr_q <= '0;
      data_cnt_q <= '0;
      sync_cnt_q <= '0;
      pkt_q <= '0;
      src_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) last_addr_q[i] <= '0;
    end else if (ld_en) begin
      if (state_q == S_SYNC) begin
        pkt_q <= '{mcode: NEXUS_MCODE_SYNC, addr: last_addr_q[rr_q]};
        src_q <= rr_q;
        valid_q <= 1'b1;
        sync_cnt_q <= sync_cnt_q + 8'd1;
        state_q <= S_DATA;
      end else if (|src_valid_i) begin
        pkt_q <= src_pkt_i[gidx];
        src_q <= gidx;
        valid_q <= 1'b1;
        last_addr_q[gidx] <= src_pkt_i[gidx].addr;
        rr_q <= gidx == SW'(NUM_SRC - 1) ? '0 : gidx + 1'b1;
        data_cnt_q <= data_cnt_d == 8'(SYNC_PERIOD) ? '0 : data_cnt_d;
        state_q <= data_cnt_d == 8'(SYNC_PERIOD) ? S_SYNC : S_DATA;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end
  assign trace_pkt_o = pkt_q;
  assign trace_src_o = src_q;
  assign trace_valid_o = valid_q;
  assign sync_cnt_o = sync_cnt_q;
endmodule

// File: tb/tb_bp_trace_funnel.sv
// tb_bp_trace_funnel: directed scenario tests of bp_trace_funnel with NUM_SRC=2, SYNC_PERIOD=4.
module tb_bp_trace_funnel;
  import bp_trace_funnel_pkg::*;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic trace_ready_i = 1'b1;
  logic [1:0] src_valid = 2'b00;
  nexus_trace_pkt_s src_pkt [2];
  logic [1:0] src_ready;
  nexus_trace_pkt_s trace_pkt;
  logic trace_src, trace_valid;
  logic [7:0] sync_cnt;
  int passed = 0;
  int total = 0;

  bp_trace_funnel #(.NUM_SRC(2), .SYNC_PERIOD(4)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .src_pkt_i(src_pkt),
    .src_valid_i(src_valid),
    .src_ready_o(src_ready),
    .trace_pkt_o(trace_pkt),
    .trace_src_o(trace_src),
    .trace_valid_o(trace_valid),
    .trace_ready_i(trace_ready_i),
    .sync_cnt_o(sync_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    src_valid = 2'b11;
    repeat (2) step();
    total++; if (trace_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", trace_valid); else passed++;
    total++; if (trace_pkt !== '0) $display("FAIL rst_pkt got %h exp 0", trace_pkt); else passed++;
    total++; if (trace_src !== 1'b0) $display("FAIL rst_src got %0d exp 0", trace_src); else passed++;
    total++; if (sync_cnt !== 8'd0) $display("FAIL rst_sync_cnt got %0d exp 0", sync_cnt); else passed++;
    total++; if (src_ready !== 2'b00) $display("FAIL rst_ready got %b exp 00", src_ready); else passed++;
    reset_i = 1'b0;
    src_valid = 2'b00;
    step();
    total++; if (trace_valid !== 1'b1) $display("FAIL first_sync_valid got %0b exp 1", trace_valid); else passed++;
    total++; if (trace_pkt.mcode !== 6'h09) $display("FAIL first_sync_mcode got %h exp 09", trace_pkt.mcode); else passed++;
    total++; if (trace_pkt.addr !== 32'h0) $display("FAIL first_sync_addr got %h exp 0", trace_pkt.addr); else passed++;
    total++; if (trace_src !== 1'b0) $display("FAIL first_sync_src got %0d exp 0", trace_src); else passed++;
    total++; if (sync_cnt !== 8'd1) $display("FAIL first_sync_cnt got %0d exp 1", sync_cnt); else passed++;
    step();
    total++; if (trace_valid !== 1'b0) $display("FAIL idle_valid got %0b exp 0", trace_valid); else passed++;
    total++; if (sync_cnt !== 8'd1) $display("FAIL idle_sync_cnt got %0d exp 1", sync_cnt); else passed++;
  endtask

  task automatic test_alternate();
    logic [1:0] rdy [10] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [31:0] last0 = 32'h0;
    logic [5:0] em;
    logic [31:0] ea;
    logic es;
    src_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      src_pkt[0] = '{mcode: NEXUS_MCODE_DIRECT_BR, addr: 32'(32'h100 + i)};
      src_pkt[1] = '{mcode: NEXUS_MCODE_INDIRECT_BR, addr: 32'(32'h200 + i)};
      #1;
      total++; if (src_ready !== rdy[i]) $display("FAIL alt_ready[%0d] got %b exp %b", i, src_ready, rdy[i]); else passed++;
      if (rdy[i] == 2'b01) begin em = 6'h03; ea = 32'(32'h100 + i); es = 1'b0; last0 = ea; end
      else if (rdy[i] == 2'b10) begin em = 6'h04; ea = 32'(32'h200 + i); es = 1'b1; end
      else begin em = 6'h09; ea = last0; es = 1'b0; end
      step();
      total++; if (trace_valid !== 1'b1 || trace_pkt.mcode !== em || trace_pkt.addr !== ea || trace_src !== es)
        $display("FAIL alt_out[%0d] got v%0b m%h a%h s%0d exp v1 m%h a%h s%0d", i, trace_valid, trace_pkt.mcode, trace_pkt.addr, trace_src, em, ea, es);
      else passed++;
    end
    src_valid = 2'b00;
    step();
    total++; if (trace_valid !== 1'b0) $display("FAIL alt_drain got %0b exp 0", trace_valid); else passed++;
    total++; if (sync_cnt !== 8'd3) $display("FAIL alt_sync_cnt got %0d exp 3", sync_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    src_valid = 2'b01;
    src_pkt[0] = '{mcode: NEXUS_MCODE_DIRECT_BR, addr: 32'h1000};
    #1;
    total++; if (src_ready !== 2'b01) $display("FAIL bp_ready0 got %b exp 01", src_ready); else passed++;
    step();
    total++; if (trace_valid !== 1'b1 || trace_pkt.addr !== 32'h1000) $display("FAIL bp_first got v%0b a%h exp v1 a00001000", trace_valid, trace_pkt.addr); else passed++;
    src_pkt[0] = '{mcode: NEXUS_MCODE_DIRECT_BR, addr: 32'h2000};
    trace_ready_i = 1'b0;
    #1;
    total++; if (src_ready !== 2'b00) $display("FAIL bp_ready_stall got %b exp 00", src_ready); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (trace_valid !== 1'b1 || trace_pkt.addr !== 32'h1000 || trace_src !== 1'b0 || src_ready !== 2'b00)
        $display("FAIL bp_hold[%0d] got v%0b a%h s%0d r%b exp v1 a00001000 s0 r00", i, trace_valid, trace_pkt.addr, trace_src, src_ready);
      else passed++;
    end
    trace_ready_i = 1'b1;
    #1;
    total++; if (src_ready !== 2'b01) $display("FAIL bp_ready_resume got %b exp 01", src_ready); else passed++;
    step();
    total++; if (trace_valid !== 1'b1 || trace_pkt.addr !== 32'h2000 || trace_src !== 1'b0) $display("FAIL bp_second got v%0b a%h s%0d exp v1 a00002000 s0", trace_valid, trace_pkt.addr, trace_src); else passed++;
    src_valid = 2'b00;
    step();
    total++; if (trace_valid !== 1'b0) $display("FAIL bp_drain got %0b exp 0", trace_valid); else passed++;
  endtask

  task automatic test_single_source();
    logic [31:0] in_a [4] = '{32'h3000, 32'h3004, 32'h3008, 32'h3008};
    logic [1:0]  rdy [4] = '{2'b10, 2'b10, 2'b00, 2'b10};
    logic [5:0]  em [4] = '{6'h04, 6'h04, 6'h09, 6'h04};
    logic [31:0] ea [4] = '{32'h3000, 32'h3004, 32'h2000, 32'h3008};
    logic        es [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    src_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      src_pkt[1] = '{mcode: NEXUS_MCODE_INDIRECT_BR, addr: in_a[i]};
      #1;
      total++; if (src_ready !== rdy[i]) $display("FAIL single_ready[%0d] got %b exp %b", i, src_ready, rdy[i]); else passed++;
      step();
      total++; if (trace_valid !== 1'b1 || trace_pkt.mcode !== em[i] || trace_pkt.addr !== ea[i] || trace_src !== es[i])
        $display("FAIL single_out[%0d] got v%0b m%h a%h s%0d exp v1 m%h a%h s%0d", i, trace_valid, trace_pkt.mcode, trace_pkt.addr, trace_src, em[i], ea[i], es[i]);
      else passed++;
    end
    src_valid = 2'b00;
    step();
    total++; if (trace_valid !== 1'b0) $display("FAIL single_drain got %0b exp 0", trace_valid); else passed++;
    total++; if (sync_cnt !== 8'd4) $display("FAIL single_sync_cnt got %0d exp 4", sync_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] rdy [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    src_valid = 2'b01;
    src_pkt[0] = '{mcode: NEXUS_MCODE_DIRECT_BR, addr: 32'h4000};
    step();
    src_pkt[0] = '{mcode: NEXUS_MCODE_DIRECT_BR, addr: 32'h4004};
    step();
    total++; if (trace_valid !== 1'b1 || trace_pkt.addr !== 32'h4004) $display("FAIL mid_pre got v%0b a%h exp v1 a00004004", trace_valid, trace_pkt.addr); else passed++;
    reset_i = 1'b1;
    #1;
    total++; if (src_ready !== 2'b00) $display("FAIL mid_ready_in_reset got %b exp 00", src_ready); else passed++;
    step();
    total++; if (trace_valid !== 1'b0 || trace_pkt !== '0 || trace_src !== 1'b0 || sync_cnt !== 8'd0)
      $display("FAIL mid_cleared got v%0b p%h s%0d c%0d exp all 0", trace_valid, trace_pkt, trace_src, sync_cnt);
    else passed++;
    reset_i = 1'b0;
    step();
    total++; if (trace_valid !== 1'b1 || trace_pkt.mcode !== 6'h09 || trace_pkt.addr !== 32'h0 || trace_src !== 1'b0 || sync_cnt !== 8'd1)
      $display("FAIL mid_sync got v%0b m%h a%h s%0d c%0d exp v1 m09 a0 s0 c1", trace_valid, trace_pkt.mcode, trace_pkt.addr, trace_src, sync_cnt);
    else passed++;
    for (int k = 0; k < 5; k++) begin
      src_pkt[0] = '{mcode: NEXUS_MCODE_DIRECT_BR, addr: 32'(32'h5000 + k)};
      #1;
      total++; if (src_ready !== rdy[k]) $display("FAIL mid_ready[%0d] got %b exp %b", k, src_ready, rdy[k]); else passed++;
      step();
      if (k < 4) begin
        total++; if (trace_pkt.mcode !== 6'h03 || trace_pkt.addr !== 32'(32'h5000 + k) || trace_src !== 1'b0)
          $display("FAIL mid_data[%0d] got m%h a%h s%0d exp m03 a%h s0", k, trace_pkt.mcode, trace_pkt.addr, trace_src, 32'(32'h5000 + k));
        else passed++;
      end else begin
        total++; if (trace_pkt.mcode !== 6'h09 || trace_pkt.addr !== 32'h0 || trace_src !== 1'b1)
          $display("FAIL mid_resync got m%h a%h s%0d exp m09 a0 s1", trace_pkt.mcode, trace_pkt.addr, trace_src);
        else passed++;
      end
    end
    src_valid = 2'b00;
    step();
  endtask

  task automatic test_sync_wrap();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    src_valid = 2'b01;
    src_pkt[0] = '{mcode: NEXUS_MCODE_DIRECT_BR, addr: 32'h6000};
    step();
    total++; if (sync_cnt !== 8'd1) $display("FAIL wrap_start got %0d exp 1", sync_cnt); else passed++;
    for (int p = 1; p < 256; p++) begin
      repeat (5) step();
      total++; if (trace_pkt.mcode !== 6'h09 || sync_cnt !== 8'(p + 1))
        $display("FAIL wrap_sync[%0d] got m%h c%0d exp m09 c%0d", p, trace_pkt.mcode, sync_cnt, 8'(p + 1));
      else passed++;
    end
    total++; if (sync_cnt !== 8'd0) $display("FAIL wrap_final got %0d exp 0", sync_cnt); else passed++;
    src_valid = 2'b00;
    step();
  endtask

  initial begin
    src_pkt[0] = '0;
    src_pkt[1] = '0;
    test_reset();
    test_alternate();
    test_backpressure();
    test_single_source();
    test_reset_mid();
    test_sync_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
